fadd_accum: RTL and testbench

//  Sequential FP32 accumulator wrapped around the combinational single-precision adder (mainmodule).
//  - Accepts a stream of LEN terms over valid/ready.
//  - Drives the adder with {running sum, next term} and registers the adder result back as the new sum.
//  - Returns the final sum over valid/ready.
//  - Sits directly upstream (operand feed) and downstream (result capture) of the adder.

---
 rtl/fadd_pkg.sv | 20 ++
 rtl/fadd_accum_if.sv | 35 +++
 rtl/fp32_classify.sv | 15 +
 rtl/fadd_accum.sv | 136 +++++++++++++
 tb/tb_fadd_accum.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fadd_pkg.sv
// Shared types and FP32 constants for the FP32 accumulator slice.
// Special-value handling is enabled by defining FADD_ACCUM_SPECIAL_EN.
package fadd_pkg;

   typedef logic [31:0] fp32_t;

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      ACC,
      ADD,
      DONE
   } fadd_accum_state_e;

   localparam fp32_t FP_ZERO = 32'h0000_0000;
   localparam fp32_t FP_QNAN = 32'h7FC0_0000;
   localparam fp32_t FP_PINF = 32'h7F80_0000;
   localparam fp32_t FP_NINF = 32'hFF80_0000;

endpackage

// File: rtl/fadd_accum_if.sv
// Bus bundle for fadd_accum: term input stream, adder operand/result loop,
// result output stream, status and a debug view of the FSM state.
interface fadd_accum_if #(
   parameter int LEN_W = 8
);
   import fadd_pkg::*;

   // Both streams: a transfer happens on a rising clk edge where valid && ready;
   // ready never depends on valid, and a presented out_data holds until taken.
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   fp32_t             in_data;
   fp32_t             add_a;
   fp32_t             add_b;
   fp32_t             add_res;
   logic              out_valid;
   logic              out_ready;
   fp32_t             out_data;
   logic              busy;
   logic              nan_flag;
   fadd_accum_state_e state;

   modport slave (
      input  start, len, in_valid, in_data, add_res, out_ready,
      output in_ready, add_a, add_b, out_valid, out_data, busy, nan_flag, state
   );

   modport master (
      output start, len, in_valid, in_data, add_res, out_ready,
      input  in_ready, add_a, add_b, out_valid, out_data, busy, nan_flag, state
   );

endinterface

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: NaN / infinity detection plus sign bit.
module fp32_classify
   import fadd_pkg::*;
(
   input  fp32_t f_i,
   output logic  is_nan_o,
   output logic  is_inf_o,
   output logic  sign_o
);

   assign is_nan_o = (f_i[30:23] == 8'hFF) && (f_i[22:0] != 23'd0);
   assign is_inf_o = (f_i[30:23] == 8'hFF) && (f_i[22:0] == 23'd0);
   assign sign_o   = f_i[31];

endmodule

// File: rtl/fadd_accum.sv
// Sequential FP32 accumulator feeding an external combinational adder.
// Define FADD_ACCUM_SPECIAL_EN for sticky NaN/Inf tracking and nan_flag.
module fadd_accum
   import fadd_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   fadd_accum_if.slave  bus
);

   fadd_accum_state_e state_q, state_d;
   fp32_t             acc_q, acc_d;
   fp32_t             b_q, b_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= FP_ZERO;
         b_q     <= FP_ZERO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.len != '0) begin
                  cnt_d   = bus.len;
                  state_d = FIRST;
               end else begin
                  acc_d   = FP_ZERO;
                  state_d = DONE;
               end
            end
         end
         // The first term is loaded directly so the adder never sees 0 + x.
         FIRST: begin
            if (bus.in_valid) begin
               acc_d = bus.in_data;
               if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? DONE : ACC;
            end
         end
         ACC: begin
            if (bus.in_valid) begin
               b_d     = bus.in_data;
               state_d = ADD;
            end
         end
         ADD: begin
            acc_d = bus.add_res;
            if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? DONE : ACC;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == FIRST) || (state_q == ACC);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.add_a     = acc_q;
   assign bus.add_b     = b_q;
   assign bus.state     = state_q;

`ifdef FADD_ACCUM_SPECIAL_EN
   logic c_nan, c_inf, c_sign;
   logic nan_q, nan_d, pinf_q, pinf_d, ninf_q, ninf_d;
   logic take, clr, invalid;

   fp32_classify u_classify (
      .f_i      (bus.in_data),
      .is_nan_o (c_nan),
      .is_inf_o (c_inf),
      .sign_o   (c_sign)
   );

   assign take = bus.in_ready && bus.in_valid;
   assign clr  = (state_q == IDLE) && bus.start && (bus.len != '0);

   always_comb begin
      nan_d  = nan_q;
      pinf_d = pinf_q;
      ninf_d = ninf_q;
      if (clr) begin
         nan_d  = 1'b0;
         pinf_d = 1'b0;
         ninf_d = 1'b0;
      end else if (take) begin
         nan_d  = nan_q  | c_nan;
         pinf_d = pinf_q | (c_inf & ~c_sign);
         ninf_d = ninf_q | (c_inf & c_sign);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nan_q  <= 1'b0;
         pinf_q <= 1'b0;
         ninf_q <= 1'b0;
      end else begin
         nan_q  <= nan_d;
         pinf_q <= pinf_d;
         ninf_q <= ninf_d;
      end
   end

   // Opposite infinities in one job are as invalid as a NaN term.
   assign invalid      = nan_q | (pinf_q & ninf_q);
   assign bus.nan_flag = invalid;
   assign bus.out_data = (state_q != DONE) ? acc_q  :
                         invalid           ? FP_QNAN :
                         pinf_q            ? FP_PINF :
                         ninf_q            ? FP_NINF : acc_q;
`else
   assign bus.nan_flag = 1'b0;
   assign bus.out_data = acc_q;
`endif

endmodule

// File: tb/tb_fadd_accum.sv
// Self-checking bench for fadd_accum: IEEE adder model on add_res, scoreboard
// of expected final sums, random and directed jobs.
module tb_fadd_accum;
   import fadd_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fadd_accum_if #(.LEN_W(8)) bus ();

   fadd_accum #(.LEN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [32:0] exp_q[$];
   fp32_t       job_terms[$];
   bit          force_low = 1'b0;

   // ---------------- reference arithmetic ----------------
   function automatic real fp32_to_real(input fp32_t f);
      logic [10:0] e11;
      if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
      e11 = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e11, f[22:0], 29'd0});
   endfunction

   // Round a double to the nearest FP32 (ties to even); normal range only.
   function automatic fp32_t real_to_fp32(input real r);
      logic [63:0] d;
      logic [10:0] e11;
      logic [24:0] m;
      logic [7:0]  ex;
      d   = $realtobits(r);
      e11 = d[62:52];
      if (e11 == 11'd0) return {d[63], 31'd0};
      ex = 8'(e11 - 11'd896);
      m  = {2'b01, d[51:29]};
      if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) begin
         ex = ex + 8'd1;
         m  = 25'd0;
      end
      return {d[63], ex, m[22:0]};
   endfunction

   function automatic fp32_t fp32_add(input fp32_t a, input fp32_t b);
      return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
   endfunction

   function automatic logic [32:0] job_expect();
      fp32_t s;
      bit    nan, pinf, ninf;
      s = FP_ZERO;
      nan = 0; pinf = 0; ninf = 0;
      foreach (job_terms[i]) begin
         s = (i == 0) ? job_terms[i] : fp32_add(s, job_terms[i]);
         if (job_terms[i][30:23] == 8'hFF) begin
            if (job_terms[i][22:0] != 23'd0) nan = 1;
            else if (job_terms[i][31]) ninf = 1;
            else pinf = 1;
         end
      end
`ifdef FADD_ACCUM_SPECIAL_EN
      if (nan || (pinf && ninf)) return {1'b1, FP_QNAN};
      if (pinf) return {1'b0, FP_PINF};
      if (ninf) return {1'b0, FP_NINF};
`endif
      return {1'b0, s};
   endfunction

   function automatic fp32_t rand_term();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(123, 131)), 23'($urandom)};
   endfunction

   always_comb bus.add_res = fp32_add(bus.add_a, bus.add_b);

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Consumer: random backpressure unless a test forces a stall.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      logic [32:0] e;
      fp32_t       prev_data;
      bit          prev_stall;
      prev_stall = 0;
      prev_data  = FP_ZERO;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid) begin
            check("busy_while_done", 32'(bus.busy), 32'd1);
            if (prev_stall) check("out_data_stable", bus.out_data, prev_data);
            if (bus.out_ready) begin
               if (exp_q.size() == 0) fail_now("unexpected_output");
               else begin
                  e = exp_q.pop_front();
                  check("out_data", bus.out_data, e[31:0]);
                  check("nan_flag", 32'(bus.nan_flag), 32'(e[32]));
               end
            end
         end
         prev_stall = rst_n && bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_term(input fp32_t t, output bit ok);
      bit rdy;
      ok = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = t;
      for (int c = 0; c < 50; c++) begin
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      if (!ok) fail_now("term_accept_timeout");
   endtask

   task automatic start_job(input int n);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.len   = 8'(n);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.len   = 8'($urandom);
   endtask

   task automatic run_job(input bit poke);
      int n, lat;
      bit ok;
      n = job_terms.size();
      exp_q.push_back(job_expect());
      start_job(n);
      if (n == 0) check("len0_done_latency", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < n; i++) begin
         send_term(job_terms[i], ok);
         if (!ok) return;
         if (poke && i == 0) begin
            bus.start = 1'b1;
            bus.len   = 8'(n + 3);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
         end
      end
      if (n > 0) begin
         lat = 0;
         while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("out_valid_latency", 32'(lat), (n >= 2) ? 32'd1 : 32'd0);
      end
      if (force_low) begin
         repeat (5) @(posedge clk);
         force_low = 1'b0;
      end
      for (int c = 0; c < 100 && bus.busy; c++) @(posedge clk);
      #1;
      if (bus.busy) fail_now("job_complete_timeout");
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = FP_ZERO;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_data", bus.out_data, FP_ZERO);
      check("rst_nan_flag", 32'(bus.nan_flag), 32'd0);
      check("rst_add_b", bus.add_b, FP_ZERO);
      rst_n = 1'b1;

      job_terms = '{32'h3F80_0000, 32'h4000_0000};
      run_job(0);
      job_terms = '{32'h3FC0_0000};
      run_job(0);
      job_terms.delete();
      run_job(0);

      force_low = 1'b1;
      job_terms = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000};
      run_job(0);

      // Abort a job after two of four terms.
      start_job(4);
      send_term(32'h3F80_0000, ok);
      send_term(32'h3F80_0000, ok);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_out_data", bus.out_data, FP_ZERO);
      check("midrst_add_a", bus.add_a, FP_ZERO);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      job_terms = '{32'h4040_0000};
      run_job(0);

`ifdef FADD_ACCUM_SPECIAL_EN
      job_terms = '{32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000};
      run_job(0);
      job_terms = '{32'h3F80_0000, 32'hFF80_0000};
      run_job(0);
`endif

      job_terms.delete();
      for (int i = 0; i < 5; i++) job_terms.push_back(rand_term());
      run_job(1);

      for (int j = 0; j < 25; j++) begin
         job_terms.delete();
         repeat ($urandom_range(0, 12)) job_terms.push_back(rand_term());
         run_job(1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
